wb_port_arbiter: RTL

//  Shares the single scalar register-file write port between the scalar pipeline (MEM/WB) and the

---
 rtl/wb_port_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the scalar register-file write port between scalar WB and the vector scalar-result path.
// Optional `WB_ARB_STATS_EN adds saturating conflict_cnt and squash_cnt outputs.
module wb_port_arbiter #(
  parameter int DATA_W     = 36,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_wbr,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_stall,
  input  logic              v_issue,
  output logic              v_issue_stall,
  input  logic              v_we,
  input  logic [ADDR_W-1:0] v_wbr,
  input  logic [DATA_W-1:0] v_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wbr,
  output logic [DATA_W-1:0] rf_data,
  output logic              err
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       squash_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [ADDR_W-1:0] q_wbr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]  q_vld, match, head_oh, tail_oh;
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     cnt, credits;
  logic [SW-1:0]     starve;
  logic              empty, full, force_pop, pop, take_s, bypass, v_hit, push, ovf, wr, inc, dec;
  always_comb begin
    empty         = cnt == '0;
    full          = cnt == CW'(DEPTH);
    force_pop     = !empty && starve == SW'(STARVE_MAX);
    pop           = !empty && (force_pop || !s_we);
    take_s        = s_we && !force_pop;
    bypass        = v_we && empty && !s_we;
    v_hit         = v_we && take_s && v_wbr == s_wbr;
    push          = v_we && !bypass && !v_hit;
    ovf           = push && full && !pop;
    wr            = push && !ovf;
    tail          = head + PW'(cnt);
    head_oh       = DEPTH'(1) << head;
    tail_oh       = DEPTH'(1) << tail;
    s_stall       = s_we && force_pop;
    v_issue_stall = ({1'b0, credits} + {1'b0, cnt}) >= (CW + 1)'(DEPTH);
    inc           = v_issue && !v_we && credits != CW'(DEPTH);
    dec           = v_we && !v_issue && credits != '0;
    match         = '0;
    for (int i = 0; i < DEPTH; i++) match[i] = take_s && q_vld[i] && q_wbr[i] == s_wbr;
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      q_wbr[tail]  <= v_wbr;
      q_data[tail] <= v_data;
    end
  end
  // Clear before set so a pop and push sharing one slot (full FIFO) keeps the new entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_vld   <= '0;
      head    <= '0;
      cnt     <= '0;
      starve  <= '0;
      credits <= '0;
      err     <= 1'b0;
      rf_we   <= 1'b0;
      rf_wbr  <= '0;
      rf_data <= '0;
    end else begin
      q_vld   <= (q_vld & ~match & ~(pop ? head_oh : '0)) | (wr ? tail_oh : '0);
      head    <= head + PW'(pop);
      cnt     <= cnt + CW'(wr) - CW'(pop);
      starve  <= (empty || pop) ? '0 : starve + SW'(1);
      credits <= credits + CW'(inc) - CW'(dec);
      err     <= err | ovf | (v_issue && v_issue_stall) | (v_we && credits == '0);
      rf_we   <= take_s || bypass || (pop && q_vld[head]);
      rf_wbr  <= take_s ? s_wbr : bypass ? v_wbr : q_wbr[head];
      rf_data <= take_s ? s_data : bypass ? v_data : q_data[head];
    end
  end
`ifdef WB_ARB_STATS_EN
  logic [16:0] sq_sum;
  always_comb begin
    sq_sum = {1'b0, squash_cnt} + 17'(v_hit);
    for (int i = 0; i < DEPTH; i++) sq_sum = sq_sum + 17'(match[i]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
      squash_cnt   <= '0;
    end else begin
      conflict_cnt <= conflict_cnt + 16'(s_we && v_we && conflict_cnt != '1);
      squash_cnt   <= sq_sum[16] ? '1 : sq_sum[15:0];
    end
  end
`endif
endmodule
